// File: rtl/inst_assembler_if.sv
// Field-set input, instruction-memory write port and status outputs of the assembler.
// Latency: n/a (bundle of wires only).
// Backpressure: in_valid/in_ready on the field side, mem_we/mem_ack on the memory side.
interface inst_assembler_if;
    // Field-set handshake and fields
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] jumper;
    logic        clear;
    // Instruction memory write port
    logic        mem_ack;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    // Status
    logic [8:0]  count;
    logic        full;
    logic        err;

    // Drives the fields and the memory acknowledge (bench / upstream side)
    modport master (
        output in_valid, fmt, op, rs, rt, rd, shamt, func, imm, jumper, clear, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    // The assembler itself
    modport slave (
        input  in_valid, fmt, op, rs, rt, rd, shamt, func, imm, jumper, clear, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/inst_assembler.sv
// Packs R/I/J instruction fields into 32-bit words and writes them to sequential memory addresses.
// Latency: mem_we asserts the cycle after accept; one instruction per 2 cycles at best.
// Backpressure: in_ready only in IDLE; WRITE holds until mem_ack; FULL blocks until clear/reset.
module inst_assembler (
    input  logic              clk,
    input  logic              reset,
    inst_assembler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;
    localparam logic [8:0] COUNT_MAX = 9'd256;

    state_t      state_q,  state_d;
    logic [7:0]  addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [8:0]  count_q,  count_d;
    logic        err_q,    err_d;
    logic [31:0] packed_w;

    // Assemble the instruction word for the presented format (illegal gives zero, never latched)
    always_comb begin
        packed_w = '0;
        case (bus.fmt)
            FMT_R:   packed_w = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
            FMT_I:   packed_w = {bus.op, bus.rs, bus.rt, bus.imm};
            FMT_J:   packed_w = {bus.op, bus.jumper};
            default: packed_w = '0;
        endcase
    end

    // Next-state logic: clear overrides everything, then the per-state accept/write behaviour
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (bus.clear) begin
            state_d = IDLE;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.fmt == FMT_ILL) begin
                            // Illegal format is consumed but only flags the error
                            err_d = 1'b1;
                        end else begin
                            wdata_d = packed_w;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        // Address wraps 255 -> 0 naturally as the buffer fills
                        addr_d = addr_q + 8'd1;
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + 9'd1;
                        end
                        state_d = (addr_q == 8'hFF) ? FULL : IDLE;
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Handshake and status outputs decode straight from the state so reset acts on them at once
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.full      = (state_q == FULL);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Directed bench for inst_assembler with hand-computed expected values.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: mem_ack driven directly to stall or release the write.
module tb_inst_assembler;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    inst_assembler_if bus ();

    inst_assembler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts a failure and reports it
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        bus.fmt = 2'b00; bus.op = op; bus.rs = rs; bus.rt = rt;
        bus.rd = rd; bus.shamt = sh; bus.func = fn;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm);
        bus.fmt = 2'b01; bus.op = op; bus.rs = rs; bus.rt = rt; bus.imm = imm;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] tgt);
        bus.fmt = 2'b10; bus.op = op; bus.jumper = tgt;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.fmt = 2'b00; bus.op = '0; bus.rs = '0; bus.rt = '0;
        bus.rd = '0; bus.shamt = '0; bus.func = '0; bus.imm = '0; bus.jumper = '0;
        bus.clear = 1'b0; bus.mem_ack = 1'b0;

        // Reset values
        #12;
        chk("rst_we",    32'(bus.mem_we),    32'd0);
        chk("rst_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_wdata", bus.mem_wdata,      32'd0);
        chk("rst_count", 32'(bus.count),     32'd0);
        chk("rst_full",  32'(bus.full),      32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready_first_edge", 32'(bus.in_ready), 32'd1);

        // R-format with ack tied high: one-cycle write
        bus.mem_ack = 1'b1;
        set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("r_we",    32'(bus.mem_we),   32'd1);
        chk("r_addr",  32'(bus.mem_addr), 32'd0);
        chk("r_wdata", bus.mem_wdata,     32'h0022_1820);
        chk("r_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("r_we_drop", 32'(bus.mem_we),   32'd0);
        chk("r_count",   32'(bus.count),    32'd1);
        chk("r_addr_inc",32'(bus.mem_addr), 32'd1);
        do_clear();
        chk("clr_count", 32'(bus.count),    32'd0);
        chk("clr_addr",  32'(bus.mem_addr), 32'd0);

        // I then J back to back at full throughput
        set_i(6'h08, 5'd1, 5'd2, 16'h0005);
        bus.in_valid = 1'b1;
        tick();
        chk("i_wdata", bus.mem_wdata,     32'h2022_0005);
        chk("i_addr",  32'(bus.mem_addr), 32'd0);
        set_j(6'h02, 26'h10);
        tick();
        chk("i_back_idle", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("j_wdata", bus.mem_wdata,     32'h0800_0010);
        chk("j_addr",  32'(bus.mem_addr), 32'd1);
        tick();
        chk("ij_count", 32'(bus.count), 32'd2);

        // Stalled write: ack low for three edges, outputs stable for four samples
        do_clear();
        bus.mem_ack = 1'b0;
        set_r(6'h3F, 5'd31, 5'd0, 5'd31, 5'd0, 6'h3F);
        bus.in_valid = 1'b1;
        tick();
        set_r(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0);
        for (int k = 0; k < 4; k++) begin
            chk("stall_we",    32'(bus.mem_we),   32'd1);
            chk("stall_addr",  32'(bus.mem_addr), 32'd0);
            chk("stall_wdata", bus.mem_wdata,     32'hFFE0_F83F);
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
            if (k < 3) tick();
        end
        bus.in_valid = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        chk("stall_done_we",    32'(bus.mem_we), 32'd0);
        chk("stall_done_count", 32'(bus.count),  32'd1);
        tick();
        tick();
        chk("ack_idle_ignored", 32'(bus.count),    32'd1);
        chk("ack_idle_addr",    32'(bus.mem_addr), 32'd1);

        // Illegal format: sticky err, no write, next legal accept still writes
        do_clear();
        bus.fmt = 2'b11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ill_err",   32'(bus.err),      32'd1);
        chk("ill_we",    32'(bus.mem_we),   32'd0);
        chk("ill_ready", 32'(bus.in_ready), 32'd1);
        chk("ill_wdata", bus.mem_wdata,     32'hFFE0_F83F);
        tick();
        chk("ill_we_later", 32'(bus.mem_we), 32'd0);
        set_j(6'h02, 26'h3FF_FFFF);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("ill_then_we",    32'(bus.mem_we), 32'd1);
        chk("ill_then_wdata", bus.mem_wdata,   32'h0BFF_FFFF);
        tick();
        chk("ill_then_count", 32'(bus.count), 32'd1);
        chk("ill_err_sticky", 32'(bus.err),   32'd1);

        // Clear during a stalled write aborts it and clears err
        bus.mem_ack = 1'b0;
        set_i(6'h01, 5'd0, 5'd0, 16'hBEEF);
        bus.in_valid = 1'b1;
        tick();
        chk("abort_we_before", 32'(bus.mem_we), 32'd1);
        bus.clear = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_we",    32'(bus.mem_we), 32'd0);
        chk("abort_count", 32'(bus.count),  32'd0);
        chk("abort_err",   32'(bus.err),    32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);

        // Fill all 256 words
        bus.mem_ack = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            set_j(6'h02, 26'(i));
            tick();
            if (i == 255) begin
                chk("fill_last_addr",  32'(bus.mem_addr), 32'd255);
                chk("fill_last_wdata", bus.mem_wdata,     32'h0800_00FF);
            end
            tick();
        end
        chk("full_flag",  32'(bus.full),     32'd1);
        chk("full_count", 32'(bus.count),    32'd256);
        chk("full_addr",  32'(bus.mem_addr), 32'd0);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("full_ignore_we",    32'(bus.mem_we), 32'd0);
        chk("full_ignore_count", 32'(bus.count),  32'd256);
        chk("full_hold",         32'(bus.full),   32'd1);
        do_clear();
        chk("full_clr_full",  32'(bus.full),     32'd0);
        chk("full_clr_count", 32'(bus.count),    32'd0);
        chk("full_clr_ready", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of a write
        bus.mem_ack = 1'b0;
        set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("mid_we", 32'(bus.mem_we), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_we",    32'(bus.mem_we),    32'd0);
        chk("arst_addr",  32'(bus.mem_addr),  32'd0);
        chk("arst_wdata", bus.mem_wdata,      32'd0);
        chk("arst_count", 32'(bus.count),     32'd0);
        chk("arst_full",  32'(bus.full),      32'd0);
        chk("arst_err",   32'(bus.err),       32'd0);
        tick();
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        set_i(6'h08, 5'd1, 5'd2, 16'h0005);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("post_rst_addr",  32'(bus.mem_addr), 32'd0);
        chk("post_rst_wdata", bus.mem_wdata,     32'h2022_0005);
        chk("post_rst_we",    32'(bus.mem_we),   32'd1);
        tick();
        chk("post_rst_count", 32'(bus.count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_assembler.md
INST_ASSEMBLER -- requirements
Module: inst_assembler

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, field set on the inputs is valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts a field set this cycle.
REQ-005 SHALL have port fmt, input, 2, instruction format: 00 R, 01 I, 10 J, 11 illegal.
REQ-006 SHALL have port op, input, 6, opcode.
REQ-007 SHALL have ports rs, rt and rd, input, 5 each, register fields.
REQ-008 SHALL have port shamt, input, 5, shift amount.
REQ-009 SHALL have port func, input, 6, function field.
REQ-010 SHALL have port imm, input, 16, immediate field.
REQ-011 SHALL have port jumper, input, 26, jump target field.
REQ-012 SHALL have port clear, input, 1, synchronous restart.
REQ-013 SHALL have port mem_ack, input, 1, instruction memory accepted the write.
REQ-014 SHALL have port mem_we, output, 1, write strobe.
REQ-015 SHALL have port mem_addr, output, 8, word address.
REQ-016 SHALL have port mem_wdata, output, 32, packed instruction.
REQ-017 SHALL have port count, output, 9, words written since reset or clear.
REQ-018 SHALL have port full, output, 1, all 256 words have been written.
REQ-019 SHALL have port err, output, 1, sticky illegal-format flag.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE and FULL.
REQ-021 SHALL drive in_ready=1 only in IDLE.
REQ-022 Accept SHALL occur when in_valid & in_ready are sampled high at a clock edge.
REQ-023 R-format accept SHALL latch {op,rs,rt,rd,shamt,func} into mem_wdata.
REQ-024 I-format accept SHALL latch {op,rs,rt,imm} into mem_wdata.
REQ-025 J-format accept SHALL latch {op,jumper} into mem_wdata.
REQ-026 Every legal accept SHALL move the FSM to WRITE.
REQ-027 An accept with fmt=11 SHALL set err, perform no write, and leave the FSM in IDLE with mem_wdata unchanged.
REQ-028 In WRITE, mem_we SHALL be 1, with mem_addr and mem_wdata held stable until mem_ack is sampled high.
REQ-029 mem_we SHALL first assert in the cycle after the accept edge.
REQ-030 On mem_ack in WRITE, mem_addr and count SHALL increment by 1; the FSM SHALL return to IDLE, or go to FULL if mem_addr was 255.
REQ-031 On the 255 -> FULL transition, mem_addr SHALL wrap to 0.
REQ-032 Peak throughput SHALL be one instruction per 2 cycles.
REQ-033 mem_ack outside WRITE SHALL be ignored.
REQ-034 In FULL, full SHALL be 1, in_ready SHALL be 0, and in_valid SHALL be ignored; only clear or reset exits FULL.
REQ-035 clear=1 at a clock edge SHALL force IDLE and zero mem_addr, count and err, regardless of state or other inputs.
REQ-036 clear in WRITE SHALL abort the write, with mem_we=0 in the following cycle.
REQ-037 clear SHALL take priority over a simultaneous accept or mem_ack.
REQ-038 count SHALL saturate at 256.
REQ-039 err SHALL remain set until clear or reset.

Reset
REQ-040 Asserting reset (low) SHALL immediately, without a clock edge, force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0 and err=0.
REQ-041 Reset asserted mid-WRITE SHALL drop mem_we immediately.
REQ-042 After reset deasserts, in_ready SHALL be 1 from the first clock edge.

Verification
REQ-043 Bench SHALL cover: R-format op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20, mem_ack tied 1 -> mem_we for one cycle, addr 0, wdata 0x00221820, count=1.
REQ-044 Bench SHALL cover: I-format op=0x08, rs=1, rt=2, imm=0x0005, then J-format op=0x02, jumper=0x10 -> wdata 0x20220005 at addr 0, then 0x08000010 at addr 1.
REQ-045 Bench SHALL cover: mem_ack held low for 3 cycles in WRITE -> mem_we, addr and data stable for 4 cycles, in_ready=0 throughout.
REQ-046 Bench SHALL cover: fmt=11 accept -> err=1, no mem_we, in_ready stays 1; a following legal accept still writes.
REQ-047 Bench SHALL cover: 256 legal writes -> full=1, count=256, mem_addr=0, further in_valid ignored; clear -> full=0, count=0, in_ready=1.
REQ-048 Bench SHALL cover: reset asserted during WRITE -> mem_we=0 immediately, all outputs at reset values, first accept after release writes to addr 0.
